// File: rtl/dsalu_pkg.sv
// Shared definitions for the digit-serial add/subtract unit.
//   dsalu_state_t : two-state controller encoding (IDLE, RUN)
//   cnt_width()   : digit counter width, max(1, clog2(W/D))
package dsalu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dsalu_state_t;

  // The counter has to hold W/D-1. With only two digits that is a single
  // bit, and clog2 would already give 1, but the floor of 1 keeps the
  // width legal for any degenerate ratio.
  function automatic int cnt_width(input int w, input int d);
    int n;
    n = w / d;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Purely combinational D-bit ripple adder. One instance handles every digit.
//   a, b   : digit operands (b is already inverted by the caller when subtracting)
//   cin    : carry into bit 0
//   s      : D-bit digit sum
//   cout   : carry out of bit D-1
//   c_msb  : carry into bit D-1, used for signed overflow on the last digit
module digit_adder #(
  parameter int D = 2
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  // c[i] is the carry into bit i. c[D] is the carry out of the digit.
  logic [D:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < D; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[D];
  assign c_msb = c[D-1];

endmodule

// File: rtl/digit_serial_alu.sv
// Digit-serial add/subtract unit. Operands arrive LSB-first, D bits per
// accepted cycle. After W/D accepted digits a W-bit result plus flags is
// presented together with a one-cycle done pulse.
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   start, sub      : begin an operation (IDLE only); sub selects A-B
//   dig_valid       : a_dig/b_dig hold a digit this cycle (low = stall)
//   a_dig, b_dig    : operand digits
//   busy            : high while digits are being consumed
//   done            : one-cycle pulse, result and flags are final
//   result          : accumulated sum/difference
//   cout, ovf       : final carry (1 = no borrow when subtracting), signed overflow
//   neg, zero       : derived from result
module digit_serial_alu
  import dsalu_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic         dig_valid,
  input  logic [D-1:0] a_dig,
  input  logic [D-1:0] b_dig,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         neg,
  output logic         zero
);

  localparam int            N        = W / D;
  localparam int            CW       = cnt_width(W, D);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  dsalu_state_t  state;
  dsalu_state_t  next_state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          mode;

  logic          start_ok;
  logic          dig_ok;
  logic          last_dig;

  logic [D-1:0]  add_s;
  logic          add_cout;
  logic          add_cmsb;

  assign start_ok = (state == IDLE) && start;
  assign dig_ok   = (state == RUN) && dig_valid;
  assign last_dig = dig_ok && (cnt == '0);

  // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
  digit_adder #(.D(D)) u_adder (
    .a     (a_dig),
    .b     (b_dig ^ {D{mode}}),
    .cin   (carry),
    .s     (add_s),
    .cout  (add_cout),
    .c_msb (add_cmsb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: leave IDLE on start, return after the last digit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)    next_state = RUN;
      RUN:     if (last_dig) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state == RUN);
  end

  // Datapath. Each accepted digit shifts in from the top so that after
  // W/D digits the first (least significant) digit sits at bit 0. Flags
  // are only written on the last digit so they stay cleared while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry  <= 1'b0;
      cnt    <= '0;
      mode   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (start_ok) begin
      mode   <= sub;
      carry  <= sub;
      cnt    <= CNT_LAST;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (dig_ok) begin
      result <= {add_s, result[W-1:D]};
      carry  <= add_cout;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) begin
        cout <= add_cout;
        ovf  <= add_cmsb ^ add_cout;
      end
    end
  end

  // Done is registered from the last-digit condition, so it appears in the
  // same cycle busy drops and never overlaps busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= last_dig;
    end
  end

  assign neg  = result[W-1];
  assign zero = (result == '0);

endmodule

// File: tb/tb_digit_serial_alu.sv
// Self-checking bench for digit_serial_alu: a W=8/D=2 instance driven from a
// vector table, random operations and hand-written corner sequences, plus a
// W=6/D=1 instance for the single-bit-digit case.
module tb_digit_serial_alu;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] mask;
    logic [7:0]  expResult;
    logic        expCout;
    logic        expOvf;
    logic        expNeg;
    logic        expZero;
    int          expCycles;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic         digValid;
  logic [D-1:0] aDig;
  logic [D-1:0] bDig;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         neg;
  logic         zero;

  logic         start6;
  logic         sub6;
  logic         digValid6;
  logic         aDig6;
  logic         bDig6;
  logic         busy6;
  logic         done6;
  logic [5:0]   result6;
  logic         cout6;
  logic         ovf6;
  logic         neg6;
  logic         zero6;

  int errors = 0;
  int checks = 0;

  digit_serial_alu #(.W(W), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .dig_valid (digValid),
    .a_dig     (aDig),
    .b_dig     (bDig),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .neg       (neg),
    .zero      (zero)
  );

  digit_serial_alu #(.W(6), .D(1)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .start     (start6),
    .sub       (sub6),
    .dig_valid (digValid6),
    .a_dig     (aDig6),
    .b_dig     (bDig6),
    .busy      (busy6),
    .done      (done6),
    .result    (result6),
    .cout      (cout6),
    .ovf       (ovf6),
    .neg       (neg6),
    .zero      (zero6)
  );

  // Free-running 10-time-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model in plain integer arithmetic: wraps the sum to 8 bits,
  // carry means "no borrow" when subtracting, overflow means the signed
  // result does not fit in 8 bits.
  function automatic void refModel(input int a, input int b, input bit s,
                                   output logic [7:0] r, output logic c,
                                   output logic o);
    int sa;
    int sb;
    int full;
    int sfull;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    if (s) begin
      full  = a - b;
      sfull = sa - sb;
      c     = (a >= b);
    end else begin
      full  = a + b;
      sfull = sa + sb;
      c     = (full > 255);
    end
    r = full[7:0];
    o = (sfull > 127) || (sfull < -128);
  endfunction

  // Edges from start to done: the start edge, one per loop iteration
  // (valid or stalled) until N digits are accepted.
  function automatic int expCycles(input logic [15:0] m);
    int v;
    int it;
    v  = 0;
    it = 0;
    while (v < N) begin
      if (it >= 16 || !m[it]) v++;
      it++;
    end
    return it + 1;
  endfunction

  // Runs one operation from the current negedge. mask bit k stalls loop
  // iteration k. junk drives a valid-looking digit in the start cycle;
  // midStart pulses start during RUN. Returns with the bench parked on the
  // negedge where done should be high.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic s, input logic [15:0] mask,
                               input bit junk, input bit midStart,
                               output int cycles, output bit busyOk,
                               output bit clearOk);
    int idx;
    int it;
    idx     = 0;
    it      = 0;
    busyOk  = 1'b1;
    start    = 1'b1;
    sub      = s;
    digValid = junk;
    aDig     = junk ? 2'(~a[1:0]) : '0;
    bDig     = junk ? 2'(b[1:0] + 2'd1) : '0;
    @(negedge clk);
    cycles  = 1;
    clearOk = (result == '0) && !cout && !ovf;
    start   = 1'b0;
    sub     = ~s;
    while (idx < N && it < 64) begin
      if (!busy || done) busyOk = 1'b0;
      digValid = (it >= 16) ? 1'b1 : !mask[it];
      aDig     = a[idx*D +: D];
      bDig     = b[idx*D +: D];
      start    = midStart && (it == 1);
      @(negedge clk);
      cycles++;
      if (digValid) idx++;
      it++;
    end
    if (idx < N) busyOk = 1'b0;
    digValid = 1'b0;
    start    = 1'b0;
    aDig     = '0;
    bDig     = '0;
  endtask

  // Compares the completion state of the W=8 instance against expectations.
  task automatic checkResult(input string tag, input logic [7:0] er,
                             input logic ec, input logic eo, input logic en,
                             input logic ez, input int ecyc, input int cycles,
                             input bit busyOk, input bit clearOk);
    checkOutput({tag, ".done"},   32'(done),    32'd1);
    checkOutput({tag, ".busy"},   32'(busy),    32'd0);
    checkOutput({tag, ".result"}, 32'(result),  32'(er));
    checkOutput({tag, ".cout"},   32'(cout),    32'(ec));
    checkOutput({tag, ".ovf"},    32'(ovf),     32'(eo));
    checkOutput({tag, ".neg"},    32'(neg),     32'(en));
    checkOutput({tag, ".zero"},   32'(zero),    32'(ez));
    checkOutput({tag, ".cycles"}, 32'(cycles),  32'(ecyc));
    checkOutput({tag, ".busyHeld"}, 32'(busyOk), 32'd1);
    checkOutput({tag, ".cleared"},  32'(clearOk), 32'd1);
  endtask

  // Main test sequence.
  initial begin
    vec_t        vecs[7];
    int          cycles;
    bit          busyOk;
    bit          clearOk;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    logic [15:0] rm;
    logic [7:0]  er;
    logic        ec;
    logic        eo;
    logic [5:0]  a6;
    logic [5:0]  b6;

    vecs[0] = '{"add5A3C",   8'h5A, 8'h3C, 1'b0, 16'h0000, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 5};
    vecs[1] = '{"sub1010",   8'h10, 8'h10, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5};
    vecs[2] = '{"sub0001",   8'h00, 8'h01, 1'b1, 16'h0000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 5};
    vecs[3] = '{"sub8001",   8'h80, 8'h01, 1'b1, 16'h0000, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 5};
    vecs[4] = '{"addFF01",   8'hFF, 8'h01, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5};
    vecs[5] = '{"add7F01",   8'h7F, 8'h01, 1'b0, 16'h0000, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 5};
    vecs[6] = '{"stall5A3C", 8'h5A, 8'h3C, 1'b0, 16'h002A, 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 8};

    rst       = 1'b0;
    start     = 1'b0;
    sub       = 1'b0;
    digValid  = 1'b0;
    aDig      = '0;
    bDig      = '0;
    start6    = 1'b0;
    sub6      = 1'b0;
    digValid6 = 1'b0;
    aDig6     = 1'b0;
    bDig6     = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.done",   32'(done),   32'd0);
    checkOutput("reset.busy",   32'(busy),   32'd0);
    checkOutput("reset.result", 32'(result), 32'd0);
    checkOutput("reset.cout",   32'(cout),   32'd0);
    checkOutput("reset.ovf",    32'(ovf),    32'd0);
    checkOutput("reset.neg",    32'(neg),    32'd0);
    checkOutput("reset.zero",   32'(zero),   32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Table vectors, each followed by an idle cycle to check the hold.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].mask, 1'b0, 1'b0,
                    cycles, busyOk, clearOk);
      checkResult(vecs[i].name, vecs[i].expResult, vecs[i].expCout,
                  vecs[i].expOvf, vecs[i].expNeg, vecs[i].expZero,
                  vecs[i].expCycles, cycles, busyOk, clearOk);
      @(negedge clk);
      checkOutput({vecs[i].name, ".doneDrop"}, 32'(done),   32'd0);
      checkOutput({vecs[i].name, ".hold"},     32'(result), 32'(vecs[i].expResult));
    end

    // Random operations issued back-to-back: each start lands in the
    // previous operation's done cycle.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rm = 16'($urandom) & 16'h0505;
      refModel(int'(ra), int'(rb), rs, er, ec, eo);
      applyStimulus(ra, rb, rs, rm, 1'b0, 1'b0, cycles, busyOk, clearOk);
      checkResult($sformatf("rand%0d", i), er, ec, eo, er[7], (er == 8'h00),
                  expCycles(rm), cycles, busyOk, clearOk);
    end
    @(negedge clk);

    // Start during RUN and digits in the start cycle must both be ignored.
    applyStimulus(8'h5A, 8'h3C, 1'b0, 16'h0000, 1'b1, 1'b1, cycles, busyOk, clearOk);
    checkResult("midStart", 8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 5, cycles, busyOk, clearOk);

    // Explicit back-to-back: start in the done cycle of the previous run.
    applyStimulus(8'h10, 8'h10, 1'b1, 16'h0000, 1'b0, 1'b0, cycles, busyOk, clearOk);
    checkResult("backToBack", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5, cycles, busyOk, clearOk);
    @(negedge clk);

    // Asynchronous reset after two accepted digits of FF+FF.
    start = 1'b1;
    sub   = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    digValid = 1'b1;
    aDig     = 2'b11;
    bDig     = 2'b11;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst.busyBefore",   32'(busy),   32'd1);
    checkOutput("rst.resultBefore", 32'(result), 32'hE0);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst.busy",   32'(busy),   32'd0);
    checkOutput("rst.done",   32'(done),   32'd0);
    checkOutput("rst.result", 32'(result), 32'd0);
    checkOutput("rst.zero",   32'(zero),   32'd1);
    digValid = 1'b0;
    aDig     = '0;
    bDig     = '0;
    @(negedge clk);
    checkOutput("rst.noDone", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst.noDoneAfter", 32'(done), 32'd0);
    applyStimulus(8'h80, 8'h01, 1'b1, 16'h0000, 1'b0, 1'b0, cycles, busyOk, clearOk);
    checkResult("afterRst", 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 5, cycles, busyOk, clearOk);
    @(negedge clk);

    // Single-bit digits, W=6: 3F + 01 wraps to zero with carry out.
    a6     = 6'h3F;
    b6     = 6'h01;
    start6 = 1'b1;
    sub6   = 1'b0;
    @(negedge clk);
    start6 = 1'b0;
    cycles = 1;
    for (int k = 0; k < 6; k++) begin
      digValid6 = 1'b1;
      aDig6     = a6[k];
      bDig6     = b6[k];
      @(negedge clk);
      cycles++;
    end
    digValid6 = 1'b0;
    checkOutput("w6.done",   32'(done6),   32'd1);
    checkOutput("w6.busy",   32'(busy6),   32'd0);
    checkOutput("w6.cycles", 32'(cycles),  32'd7);
    checkOutput("w6.result", 32'(result6), 32'd0);
    checkOutput("w6.cout",   32'(cout6),   32'd1);
    checkOutput("w6.zero",   32'(zero6),   32'd1);
    checkOutput("w6.ovf",    32'(ovf6),    32'd0);
    checkOutput("w6.neg",    32'(neg6),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_alu.md
# digit_serial_alu

Parametrised digit-serial add/subtract unit: consumes two operands LSB-first, D bits per cycle, over W/D accepted digits, and produces a W-bit parallel result with carry, zero, negative and signed-overflow flags. It generalises the bit-serial adder datapath in several ways:
- digit width D instead of a fixed single bit;
- run-time add/subtract mode;
- per-digit valid handshake that allows stalls;
- a registered one-cycle completion pulse with result and flags held afterwards.

It sits between serial operand sources and parallel result consumers.

## Interface
- W, default 8: operand/result width; must be a multiple of D.
- D, default 2: digit width (bits consumed per accepted cycle); D ≥ 1, W/D ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin operation; honoured only in IDLE.
- sub  in  1  mode, sampled with accepted start: 0 = A+B, 1 = A−B.
- dig_valid  in  1  a_dig/b_dig carry a valid digit this cycle.
- a_dig  in  D  operand A digit, LSB-first order.
- b_dig  in  D  operand B digit, LSB-first order.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse: result and flags are final.
- result  out  W  accumulated sum/difference.
- cout  out  1  final carry out (for subtract: 1 = no borrow).
- ovf  out  1  two's-complement overflow.
- neg  out  1  result[W-1].
- zero  out  1  result == 0.

## Operation
- Reset values: state IDLE, carry 0, digit counter 0, mode 0, result 0, cout 0, ovf 0, done 0, busy 0.
- Derived outputs: neg and zero are combinational from result. Reset therefore gives zero = 1 and neg = 0.
- FSM states are IDLE and RUN.
- IDLE → RUN on start:
  - latch sub;
  - carry ← sub (two's-complement +1);
  - counter ← W/D−1;
  - clear result, cout and ovf.
- Start in RUN is ignored. Start is not a data cycle: digits present in the start cycle are ignored.
- RUN, dig_valid=1 (accepted digit):
  - s = a_dig + (b_dig ^ {D{sub}}) + carry, computed as a ripple across D bits;
  - result ← {s[D-1:0], result[W-1:D]};
  - carry ← carry out of the digit;
  - counter decrements.
- RUN, dig_valid=0: hold all state (stall).
- Final digit (counter == 0 and dig_valid=1):
  - cout ← digit carry out;
  - ovf ← carry into bit D-1 XOR carry out of bit D-1;
  - next state IDLE;
  - done = 1 next cycle.
- After done: result, cout and ovf hold until the next accepted start.
- Reset mid-operation: immediate return to the reset values above; no done pulse.
- Width rules:
  - counter width is max(1, $clog2(W/D));
  - all digit arithmetic is D+1 bits, modulo 2^W overall;
  - no saturation.

## Timing
- Without stalls: start accepted at edge 0, digits accepted at edges 1…W/D, done high in the cycle after edge W/D.
- Latency from start to done is W/D+1 cycles, plus one cycle per stalled cycle.
- busy rises the cycle after start and falls in the same cycle done rises.
- done is registered: never asserted while busy is high.
- Back-to-back: start may be asserted in the done cycle (state IDLE). The new operation begins next edge, and result clears at that edge.
- Result is a partially shifted value while busy; it is valid only from done onward.

## Structure
- Package dsalu_pkg:
  - typedef enum logic {IDLE, RUN} dsalu_state_t;
  - function for counter width (max(1, $clog2(W/D))).
- Sub-module digit_adder #(D):
  - inputs a, b, cin; outputs s[D-1:0], cout, c_msb (carry into bit D-1);
  - purely combinational ripple;
  - reused for every digit.
- Top: FSM, digit counter, carry flop, mode flop, result shift register, flag registers, done flop.

## Test plan
1. W=8, D=2, sub=0, A=0x5A, B=0x3C, no stalls → done at cycle 5 after start; result 0x96, cout 0, ovf 1, neg 1, zero 0.
2. W=8, D=2, sub=1, A=0x10, B=0x10 → result 0x00, zero 1, cout 1, ovf 0. Then sub=1, A=0x00, B=0x01 → result 0xFF, cout 0, neg 1. Then sub=1, A=0x80, B=0x01 → result 0x7F, ovf 1.
3. Stalls: scenario 1 with dig_valid low on 3 scattered cycles → identical result and flags; done at cycle 8; busy held throughout.
4. Start pulsed mid-RUN and digits presented in the start cycle → both ignored; result unchanged versus the clean run. Back-to-back start in the done cycle → second operation correct.
5. Reset: rst low after 2 accepted digits → all outputs at reset values asynchronously; no done. A new operation after release is correct.
6. W=6, D=1, sub=0, A=0x3F, B=0x01 → done at cycle 7; result 0x00, cout 1, zero 1, ovf 0.
